// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared state encodings and host command bytes for the acquisition sequencer
package acq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        ACQ  = 2'd2,
        TXD  = 2'd3
    } seq_state_t;

    typedef enum logic [2:0] {
        P_CMD  = 3'd0,
        P_MASK = 3'd1,
        P_PAT  = 3'd2,
        P_NHI  = 3'd3,
        P_NLO  = 3'd4
    } parse_state_t;

    localparam logic [7:0] CMD_ABORT = 8'd98;
    localparam logic [7:0] CMD_RUN   = 8'd114;
    localparam logic [7:0] CMD_CONT  = 8'd99;
    localparam logic [7:0] CMD_MASK  = 8'd109;
    localparam logic [7:0] CMD_PAT   = 8'd112;
    localparam logic [7:0] CMD_NSAMP = 8'd110;

    // A zero sample count would stall the capture engine, so it is promoted to one.
    function automatic logic [15:0] clamp_samples(input logic [15:0] n);
        return (n == 16'd0) ? 16'd1 : n;
    endfunction

endpackage

// File: rtl/cmd_parser.sv
// rtl/cmd_parser.sv - host byte parser holding trigger and sample-count configuration
module cmd_parser
    import acq_pkg::*;
#(
    parameter int PROBE_W     = 8,
    parameter int DEF_SAMPLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_data_fresh,
    input  logic               busy,
    output logic [PROBE_W-1:0] trig_mask,
    output logic [PROBE_W-1:0] trig_pattern,
    output logic [15:0]        sample_count,
    output logic               start,
    output logic               start_cont,
    output logic               abort,
    output logic               cmd_err
);

    parse_state_t       pstate_q, pstate_d;
    logic [PROBE_W-1:0] mask_q, mask_d;
    logic [PROBE_W-1:0] pat_q, pat_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         nhi_q, nhi_d;

    always_comb begin
        pstate_d   = pstate_q;
        mask_d     = mask_q;
        pat_d      = pat_q;
        cnt_d      = cnt_q;
        nhi_d      = nhi_q;
        start      = 1'b0;
        start_cont = 1'b0;
        abort      = 1'b0;
        cmd_err    = 1'b0;
        if (rx_data_fresh) begin
            case (pstate_q)
                P_CMD: begin
                    case (rx_data)
                        CMD_ABORT: abort = 1'b1;
                        CMD_RUN, CMD_CONT: begin
                            if (busy) begin
                                cmd_err = 1'b1;
                            end else begin
                                start      = 1'b1;
                                start_cont = (rx_data == CMD_CONT);
                            end
                        end
                        CMD_MASK:  if (busy) cmd_err = 1'b1; else pstate_d = P_MASK;
                        CMD_PAT:   if (busy) cmd_err = 1'b1; else pstate_d = P_PAT;
                        CMD_NSAMP: if (busy) cmd_err = 1'b1; else pstate_d = P_NHI;
                        default:   cmd_err = 1'b1;
                    endcase
                end
                // Argument bytes are raw data; an abort value here is not a command.
                P_MASK: begin
                    mask_d   = rx_data[PROBE_W-1:0];
                    pstate_d = P_CMD;
                end
                P_PAT: begin
                    pat_d    = rx_data[PROBE_W-1:0];
                    pstate_d = P_CMD;
                end
                P_NHI: begin
                    nhi_d    = rx_data;
                    pstate_d = P_NLO;
                end
                P_NLO: begin
                    cnt_d    = clamp_samples({nhi_q, rx_data});
                    pstate_d = P_CMD;
                end
                default: pstate_d = P_CMD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate_q <= P_CMD;
            mask_q   <= '0;
            pat_q    <= '0;
            cnt_q    <= 16'(DEF_SAMPLES);
            nhi_q    <= '0;
        end else begin
            pstate_q <= pstate_d;
            mask_q   <= mask_d;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            nhi_q    <= nhi_d;
        end
    end

    assign trig_mask    = mask_q;
    assign trig_pattern = pat_q;
    assign sample_count = cnt_q;

endmodule

// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - IDLE/ARM/ACQ/TXD capture sequencer; ACQ_TIMEOUT_EN adds an ACQ watchdog
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int PROBE_W        = 8,
    parameter int DEF_SAMPLES    = 1024,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_data_fresh,
    input  logic [PROBE_W-1:0] probe,
    input  logic               done_acq,
    input  logic               done_txd,
    output logic               grant_acq,
    output logic               grant_txd,
    output logic [15:0]        sample_count,
    output logic [PROBE_W-1:0] trig_mask,
    output logic [PROBE_W-1:0] trig_pattern,
    output logic               busy,
    output logic               err
);

    seq_state_t state_q, state_d;
    logic       cont_q, cont_d;
    logic       grant_acq_q, grant_txd_q, err_q;
    logic       start, start_cont, abort, cmd_err;
    logic       trig_match;
    logic       tmo_err;

    cmd_parser #(
        .PROBE_W    (PROBE_W),
        .DEF_SAMPLES(DEF_SAMPLES)
    ) u_parser (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_data_fresh(rx_data_fresh),
        .busy         (busy),
        .trig_mask    (trig_mask),
        .trig_pattern (trig_pattern),
        .sample_count (sample_count),
        .start        (start),
        .start_cont   (start_cont),
        .abort        (abort),
        .cmd_err      (cmd_err)
    );

    assign trig_match = ((probe & trig_mask) == (trig_pattern & trig_mask));

`ifdef ACQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counter is zero in every cycle outside ACQ, so it restarts on each ACQ entry.
    always_comb begin
        tmo_d = '0;
        if (state_q == ACQ) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cont_d  = cont_q;
        tmo_err = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cont_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = ARM;
                        cont_d  = start_cont;
                    end
                end
                ARM: begin
                    if (trig_match) begin
                        state_d = ACQ;
                    end
                end
                ACQ: begin
                    if (done_acq) begin
                        state_d = TXD;
`ifdef ACQ_TIMEOUT_EN
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = IDLE;
                        cont_d  = 1'b0;
                        tmo_err = 1'b1;
`endif
                    end
                end
                TXD: begin
                    if (done_txd) begin
                        state_d = cont_q ? ARM : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cont_q      <= 1'b0;
            grant_acq_q <= 1'b0;
            grant_txd_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cont_q      <= cont_d;
            grant_acq_q <= (state_d == ACQ);
            grant_txd_q <= (state_d == TXD);
            err_q       <= cmd_err | tmo_err;
        end
    end

    assign grant_acq = grant_acq_q;
    assign grant_txd = grant_txd_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_acq_sequencer.sv
// tb/tb_acq_sequencer.sv - randomized self-checking bench for acq_sequencer
module tb_acq_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_data_fresh;
    logic [7:0]  probe;
    logic        done_acq, done_txd;
    logic        grant_acq, grant_txd, busy, err;
    logic [15:0] sample_count;
    logic [7:0]  trig_mask, trig_pattern;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  m_mask, m_pat;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    acq_sequencer #(
        .PROBE_W       (8),
        .DEF_SAMPLES   (1024),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_data_fresh(rx_data_fresh),
        .probe        (probe),
        .done_acq     (done_acq),
        .done_txd     (done_txd),
        .grant_acq    (grant_acq),
        .grant_txd    (grant_txd),
        .sample_count (sample_count),
        .trig_mask    (trig_mask),
        .trig_pattern (trig_pattern),
        .busy         (busy),
        .err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic e);
        rx_data       = b;
        rx_data_fresh = 1'b1;
        tick();
        e             = err;
        rx_data_fresh = 1'b0;
    endtask

    function automatic logic [15:0] model_nsamp(input logic [7:0] hi, input logic [7:0] lo);
        int v;
        v = hi * 256 + lo;
        if (v == 0) v = 1;
        return v[15:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1; rx_data = 8'h00; rx_data_fresh = 1'b0; probe = 8'h00;
        done_acq = 1'b0; done_txd = 1'b0;
        tick(); tick();
        rst = 1'b0;
        m_mask = 8'h00; m_pat = 8'h00; m_cnt = 16'd1024;
        checks++; if (grant_acq !== 1'b0) begin failures++; $display("FAIL reset_grant_acq got=%0b exp=0", grant_acq); end
        checks++; if (grant_txd !== 1'b0) begin failures++; $display("FAIL reset_grant_txd got=%0b exp=0", grant_txd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
        checks++; if (trig_mask !== 8'h00) begin failures++; $display("FAIL reset_mask got=%h exp=00", trig_mask); end
        checks++; if (trig_pattern !== 8'h00) begin failures++; $display("FAIL reset_pattern got=%h exp=00", trig_pattern); end
        checks++; if (sample_count !== 16'd1024) begin failures++; $display("FAIL reset_count got=%0d exp=1024", sample_count); end
    endtask

    task automatic test_config();
        logic e, e_any;
        logic [7:0] a, b;
        int op;
        e_any = 1'b0;
        send_byte("m", e); e_any |= e; send_byte(8'h0F, e); e_any |= e;
        send_byte("p", e); e_any |= e; send_byte(8'h05, e); e_any |= e;
        send_byte("n", e); e_any |= e; send_byte(8'h00, e); e_any |= e; send_byte(8'h40, e); e_any |= e;
        m_mask = 8'h0F; m_pat = 8'h05; m_cnt = 16'd64;
        checks++; if (trig_mask !== 8'h0F) begin failures++; $display("FAIL cfg_mask got=%h exp=0f", trig_mask); end
        checks++; if (trig_pattern !== 8'h05) begin failures++; $display("FAIL cfg_pattern got=%h exp=05", trig_pattern); end
        checks++; if (sample_count !== 16'd64) begin failures++; $display("FAIL cfg_count got=%0d exp=64", sample_count); end
        checks++; if (e_any !== 1'b0) begin failures++; $display("FAIL cfg_err got=%0b exp=0", e_any); end
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 2);
            a = 8'($urandom); b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin a = 8'h00; b = 8'h00; end
            e_any = 1'b0;
            case (op)
                0: begin send_byte("m", e); e_any |= e; send_byte(a, e); e_any |= e; m_mask = a; end
                1: begin send_byte("p", e); e_any |= e; send_byte(a, e); e_any |= e; m_pat = a; end
                default: begin
                    send_byte("n", e); e_any |= e; send_byte(a, e); e_any |= e; send_byte(b, e); e_any |= e;
                    m_cnt = model_nsamp(a, b);
                end
            endcase
            checks++; if (trig_mask !== m_mask) begin failures++; $display("FAIL rcfg_mask it=%0d got=%h exp=%h", i, trig_mask, m_mask); end
            checks++; if (trig_pattern !== m_pat) begin failures++; $display("FAIL rcfg_pattern it=%0d got=%h exp=%h", i, trig_pattern, m_pat); end
            checks++; if (sample_count !== m_cnt) begin failures++; $display("FAIL rcfg_count it=%0d got=%h exp=%h", i, sample_count, m_cnt); end
            checks++; if (e_any !== 1'b0) begin failures++; $display("FAIL rcfg_err it=%0d got=%0b exp=0", i, e_any); end
        end
    endtask

    task automatic test_oneshot();
        logic e;
        send_byte("m", e); send_byte(8'h0F, e); send_byte("p", e); send_byte(8'h05, e);
        m_mask = 8'h0F; m_pat = 8'h05;
        probe = 8'h00;
        send_byte("r", e);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL os_busy got=%0b exp=1", busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (grant_acq !== 1'b0) begin failures++; $display("FAIL os_arm_hold cyc=%0d got=%0b exp=0", i, grant_acq); end
        end
        probe = 8'hA5;
        tick();
        checks++; if (grant_acq !== 1'b1) begin failures++; $display("FAIL os_grant_acq got=%0b exp=1", grant_acq); end
        probe = 8'h00;
        done_acq = 1'b1; tick(); done_acq = 1'b0;
        checks++; if (grant_txd !== 1'b1 || grant_acq !== 1'b0) begin failures++; $display("FAIL os_txd got=%0b%0b exp=01", grant_acq, grant_txd); end
        done_txd = 1'b1; tick(); done_txd = 1'b0;
        checks++; if (busy !== 1'b0 || grant_txd !== 1'b0) begin failures++; $display("FAIL os_idle busy=%0b txd=%0b exp=0 0", busy, grant_txd); end
    endtask

    task automatic test_trigger_random();
        logic e, exp_g;
        for (int it = 0; it < 6; it++) begin
            m_mask = 8'($urandom); m_pat = 8'($urandom);
            if (it == 0) m_mask = 8'hFF;
            send_byte("m", e); send_byte(m_mask, e); send_byte("p", e); send_byte(m_pat, e);
            send_byte("r", e);
            for (int c = 0; c < 40; c++) begin
                probe = 8'($urandom);
                if ($urandom_range(0, 5) == 0) probe = (m_pat & m_mask) | (8'($urandom) & ~m_mask);
                if (c == 39) probe = m_pat;
                exp_g = ((probe & m_mask) == (m_pat & m_mask));
                done_txd = 1'b1;
                tick();
                done_txd = 1'b0;
                checks++; if (grant_acq !== exp_g) begin failures++; $display("FAIL rtrig it=%0d cyc=%0d probe=%h got=%0b exp=%0b", it, c, probe, grant_acq, exp_g); end
                if (exp_g) break;
            end
            done_txd = 1'b1; tick(); done_txd = 1'b0;
            checks++; if (grant_acq !== 1'b1) begin failures++; $display("FAIL rtrig_txd_ignored it=%0d got=%0b exp=1", it, grant_acq); end
            done_acq = 1'b1; tick(); done_acq = 1'b0;
            done_txd = 1'b1; tick(); done_txd = 1'b0;
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rtrig_idle it=%0d got=%0b exp=0", it, busy); end
        end
        probe = 8'h00;
    endtask

    task automatic test_continuous();
        logic e;
        send_byte("m", e); send_byte(8'h00, e); m_mask = 8'h00;
        send_byte("c", e);
        checks++; if (busy !== 1'b1 || grant_acq !== 1'b0) begin failures++; $display("FAIL cont_arm busy=%0b acq=%0b exp=1 0", busy, grant_acq); end
        tick();
        checks++; if (grant_acq !== 1'b1) begin failures++; $display("FAIL cont_acq got=%0b exp=1", grant_acq); end
        for (int r = 0; r < 3; r++) begin
            done_acq = 1'b1; tick(); done_acq = 1'b0;
            checks++; if (grant_txd !== 1'b1) begin failures++; $display("FAIL cont_txd r=%0d got=%0b exp=1", r, grant_txd); end
            done_txd = 1'b1; tick(); done_txd = 1'b0;
            checks++; if (grant_acq !== 1'b0 || grant_txd !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL cont_rearm r=%0d acq=%0b txd=%0b busy=%0b exp=0 0 1", r, grant_acq, grant_txd, busy); end
            tick();
            checks++; if (grant_acq !== 1'b1) begin failures++; $display("FAIL cont_reacq r=%0d got=%0b exp=1", r, grant_acq); end
        end
        send_byte("b", e);
        checks++; if (busy !== 1'b0 || grant_acq !== 1'b0 || grant_txd !== 1'b0) begin
            failures++; $display("FAIL cont_abort busy=%0b acq=%0b txd=%0b exp=0 0 0", busy, grant_acq, grant_txd); end
    endtask

    task automatic test_conflict();
        logic e;
        send_byte("r", e); tick();
        checks++; if (grant_acq !== 1'b1) begin failures++; $display("FAIL conf_acq got=%0b exp=1", grant_acq); end
        rx_data = "b"; rx_data_fresh = 1'b1; done_acq = 1'b1;
        tick();
        rx_data_fresh = 1'b0; done_acq = 1'b0;
        checks++; if (busy !== 1'b0 || grant_acq !== 1'b0 || grant_txd !== 1'b0) begin
            failures++; $display("FAIL conf_abort busy=%0b acq=%0b txd=%0b exp=0 0 0", busy, grant_acq, grant_txd); end
        tick();
        checks++; if (grant_txd !== 1'b0) begin failures++; $display("FAIL conf_no_txd got=%0b exp=0", grant_txd); end
        send_byte("r", e);
        send_byte("m", e);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL busy_m_err got=%0b exp=1", e); end
        send_byte(8'h33, e);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL busy_unknown_err got=%0b exp=1", e); end
        checks++; if (trig_mask !== m_mask) begin failures++; $display("FAIL busy_mask got=%h exp=%h", trig_mask, m_mask); end
        send_byte("r", e);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL busy_r_err got=%0b exp=1", e); end
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%0b exp=0", err); end
        send_byte("b", e);
        done_acq = 1'b1; tick(); done_acq = 1'b0;
        checks++; if (busy !== 1'b0 || grant_txd !== 1'b0) begin failures++; $display("FAIL idle_done busy=%0b txd=%0b exp=0 0", busy, grant_txd); end
        send_byte("x", e);
        checks++; if (e !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL idle_unknown err=%0b busy=%0b exp=1 0", e, busy); end
    endtask

    task automatic test_args();
        logic e, e_any;
        e_any = 1'b0;
        send_byte("n", e); e_any |= e; send_byte(8'd98, e); e_any |= e; send_byte(8'h00, e); e_any |= e;
        m_cnt = model_nsamp(8'd98, 8'h00);
        checks++; if (sample_count !== m_cnt) begin failures++; $display("FAIL arg_98 got=%h exp=%h", sample_count, m_cnt); end
        checks++; if (e_any !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL arg_98_flags err=%0b busy=%0b exp=0 0", e_any, busy); end
        send_byte("n", e); send_byte(8'h00, e); send_byte(8'h00, e);
        checks++; if (sample_count !== 16'd1) begin failures++; $display("FAIL arg_zero got=%0d exp=1", sample_count); end
    endtask

`ifdef ACQ_TIMEOUT_EN
    task automatic test_timeout();
        logic e;
        send_byte("m", e); send_byte(8'h00, e); m_mask = 8'h00;
        send_byte("c", e); tick();
        checks++; if (grant_acq !== 1'b1) begin failures++; $display("FAIL tmo_enter got=%0b exp=1", grant_acq); end
        for (int i = 0; i < 15; i++) tick();
        checks++; if (grant_acq !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL tmo_early acq=%0b err=%0b exp=1 0", grant_acq, err); end
        tick();
        checks++; if (busy !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL tmo_fire busy=%0b err=%0b exp=0 1", busy, err); end
        tick();
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL tmo_once err=%0b busy=%0b exp=0 0", err, busy); end
    endtask
`endif

    task automatic test_reset_mid();
        logic e;
        send_byte("m", e); send_byte(8'h00, e);
        send_byte("r", e); tick();
        done_acq = 1'b1; tick(); done_acq = 1'b0;
        checks++; if (grant_txd !== 1'b1) begin failures++; $display("FAIL rmid_txd got=%0b exp=1", grant_txd); end
        rst = 1'b1; tick(); rst = 1'b0;
        m_mask = 8'h00; m_pat = 8'h00; m_cnt = 16'd1024;
        checks++; if (grant_acq !== 1'b0 || grant_txd !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL rmid_ctrl acq=%0b txd=%0b busy=%0b err=%0b exp=0 0 0 0", grant_acq, grant_txd, busy, err); end
        checks++; if (sample_count !== m_cnt || trig_pattern !== m_pat) begin
            failures++; $display("FAIL rmid_cfg cnt=%0d pat=%h exp=%0d %h", sample_count, trig_pattern, m_cnt, m_pat); end
        send_byte("m", e);
        rst = 1'b1; tick(); rst = 1'b0;
        send_byte(8'h11, e);
        checks++; if (e !== 1'b1 || trig_mask !== 8'h00) begin
            failures++; $display("FAIL rmid_parser err=%0b mask=%h exp=1 00", e, trig_mask); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_oneshot();
        test_trigger_random();
        test_continuous();
        test_conflict();
        test_args();
`ifdef ACQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Command-driven controller for the logic analyser capture path. Parses host bytes from the UART receiver and holds trigger and sample-count configuration for the acquisition unit.
- Sequences IDLE, ARM, ACQ and TXD phases, issuing exclusive grants to the acquisition and transmit engines.
- Sits between the UART RX, the probe inputs, and the acquisition/transmit engines.

Parameters:
- PROBE_W, 8, probe bus width; trigger mask and pattern width (1..8).
- DEF_SAMPLES, 1024, reset value of sample_count.
- TIMEOUT_CYCLES, 2**20, ACQ watchdog limit; used only with ACQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rx_data  in  8  received byte; valid when rx_data_fresh=1.
- rx_data_fresh  in  1  one-cycle strobe per received byte.
- probe  in  PROBE_W  synchronised probe inputs.
- done_acq  in  1  acquisition engine finished (level, sampled on clk).
- done_txd  in  1  transmit engine finished (level, sampled on clk).
- grant_acq  out  1  acquisition engine enable.
- grant_txd  out  1  transmit engine enable.
- sample_count  out  16  samples to capture; held stable outside IDLE.
- trig_mask  out  PROBE_W  trigger mask (1 = bit compared).
- trig_pattern  out  PROBE_W  trigger compare value.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  one-cycle pulse on a rejected command or timeout.

Behaviour:
- Reset values:
  - state=IDLE, parser=P_CMD.
  - grant_acq=0, grant_txd=0, busy=0, err=0.
  - trig_mask=0, trig_pattern=0, sample_count=DEF_SAMPLES.
  - continuous=0.
- Reset mid-operation: grants drop on the next clk edge; no argument or partial state survives.
- Parser states:
  - P_CMD, P_MASK, P_PAT, P_NHI, P_NLO.
  - Advances only on rx_data_fresh.
  - In argument states every byte is raw data, including 98.
- Commands in P_CMD:
  - 'b' (98): abort. state goes to IDLE next cycle from any state, continuous is cleared, grants drop.
  - 'r' (114): from IDLE, enter ARM with continuous=0.
  - 'c' (99): from IDLE, enter ARM with continuous=1.
  - 'm' (109): go to P_MASK; the next byte's low PROBE_W bits load trig_mask.
  - 'p' (112): go to P_PAT; the next byte loads trig_pattern.
  - 'n' (110): go to P_NHI then P_NLO; two bytes, MSB first, load sample_count. The load happens after the second byte.
  - A value of 0 is stored as 1.
- Command rejection:
  - 'r', 'c', 'm', 'p' or 'n' received while busy=1: ignored, err pulses, parser stays in P_CMD.
  - Unknown byte in P_CMD: ignored, err pulses.
- Sequencer:
  - IDLE -> ARM on 'r' or 'c'.
  - ARM -> ACQ when (probe & trig_mask) == (trig_pattern & trig_mask), evaluated each cycle. With mask=0, ACQ is entered on the cycle after ARM.
  - ACQ -> TXD when done_acq=1.
  - TXD -> ARM when done_txd=1 and continuous=1.
  - TXD -> IDLE when done_txd=1 and continuous=0.
- Grant outputs:
  - grant_acq = (state==ACQ); grant_txd = (state==TXD). Both are registered and never high together.
  - Latency: grant_acq rises 1 cycle after the trigger match cycle.
- Priority: abort and rst beat any done or trigger in the same cycle. A done_* input outside its own state is ignored.

Optional Feature:
- ACQ_TIMEOUT_EN defined:
  - A cycle counter resets on ACQ entry.
  - If done_acq is not seen within TIMEOUT_CYCLES cycles in ACQ: state goes to IDLE, continuous is cleared, err pulses once.
- ACQ_TIMEOUT_EN undefined: no counter; ACQ waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package acq_pkg holds:
  - sequencer state encoding (IDLE, ARM, ACQ, TXD) and parser state encoding;
  - command byte constants CMD_ABORT=98, CMD_RUN=114, CMD_CONT=99, CMD_MASK=109, CMD_PAT=112, CMD_NSAMP=110.
- One sub-module, cmd_parser: byte FSM plus config registers. It outputs start/cont/abort/err pulses to the top-level sequencer FSM.

Test Plan:
- Config: send 'm',0x0F,'p',0x05,'n',0x00,0x40 -> trig_mask=0x0F, trig_pattern=0x05, sample_count=64, err stays 0.
- One-shot trigger: 'r' with probe=0x00, then probe=0xA5 -> ARM holds; grant_acq rises 1 cycle after the match. done_acq -> grant_txd=1. done_txd -> IDLE, busy=0.
- Continuous mode: 'c' with mask=0 -> ACQ on the 2nd cycle. After done_txd, returns to ARM then ACQ repeatedly. 'b' -> IDLE next cycle with both grants 0.
- Same-cycle conflict: 'b' in the same cycle as done_acq -> IDLE, grant_txd never asserts. 'm' while busy -> err pulse, trig_mask unchanged.
- Argument handling: 'n' followed by 98 then 0x00 -> sample_count=0x6200, no abort. 'n',0x00,0x00 -> sample_count=1.
- ACQ_TIMEOUT_EN with TIMEOUT_CYCLES=16: hold done_acq=0 in ACQ -> after 16 cycles, IDLE plus one err pulse. rst mid-TXD -> all outputs at reset values next cycle.
